// File: rtl/fifo_pkg.sv
// Shared helpers for the entry FIFO: one-hot check, one-hot-to-index and popcount.
package fifo_pkg;

  localparam int unsigned MaxWidth = 64;

  function automatic logic is_onehot(input logic [MaxWidth-1:0] v);
    return (v != '0) && ((v & (v - MaxWidth'(1))) == '0);
  endfunction

  // Assumes v is one-hot; OR-ing indices keeps the logic a flat reduction.
  function automatic int unsigned onehot_to_idx(input logic [MaxWidth-1:0] v);
    int unsigned idx = 0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

  function automatic int unsigned popcount(input logic [MaxWidth-1:0] v,
                                           input int unsigned width);
    int unsigned cnt = 0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i < width) cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/onehot_mux.sv
// WIDTH-way AND-OR mux selecting one data word by a one-hot select.
module onehot_mux #(
  parameter int unsigned Width = 6,
  parameter int unsigned DataW = 32
) (
  input  logic [Width-1:0]            sel_i,
  input  logic [Width-1:0][DataW-1:0] data_i,
  output logic [DataW-1:0]            data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < int'(Width); i++) begin
      data_o = data_o | (data_i[i] & {DataW{sel_i[i]}});
    end
  end

endmodule

// File: rtl/fifo_head_dequeue.sv
// Read side of the circular entry FIFO: storage, occupancy vector and one-hot head.
// Optional sticky illegal-write flag `err` is built when FIFO_DEQ_ERR_EN is defined.
module fifo_head_dequeue
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_entry,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_ready,
`ifdef FIFO_DEQ_ERR_EN
  output logic                       err,
`endif
  output logic [WIDTH-1:0]           valid_entry,
  output logic [$clog2(WIDTH+1)-1:0] count,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [WIDTH-1:0]           rd_entry
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CntW = $clog2(WIDTH+1);

  logic [WIDTH-1:0]             valid_q, valid_d;
  logic [WIDTH-1:0]             head_q, head_d;
  logic [WIDTH-1:0][DATA_W-1:0] mem_q, mem_d;

  logic            wr_legal;
  logic            deq;
  logic [IdxW-1:0] wr_idx;

  // An entry being dequeued is still occupied at the edge, so writing it is illegal.
  assign wr_legal = wr_en && is_onehot(MaxWidth'(wr_entry))
                    && ((wr_entry & valid_q) == '0);
  assign deq      = rd_valid && rd_ready;
  assign wr_idx   = IdxW'(onehot_to_idx(MaxWidth'(wr_entry)));

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    mem_d   = mem_q;
    if (flush) begin
      valid_d = '0;
      head_d  = WIDTH'(1);
    end else begin
      if (deq) begin
        valid_d = valid_d & ~head_q;
        head_d  = {head_q[WIDTH-2:0], head_q[WIDTH-1]};
      end
      if (wr_legal) begin
        valid_d        = valid_d | wr_entry;
        mem_d[wr_idx]  = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= WIDTH'(1);
      mem_q   <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      mem_q   <= mem_d;
    end
  end

`ifdef FIFO_DEQ_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q | (wr_en & ~wr_legal & ~flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

  onehot_mux #(
    .Width(WIDTH),
    .DataW(DATA_W)
  ) u_rd_mux (
    .sel_i (head_q),
    .data_i(mem_q),
    .data_o(rd_data)
  );

  assign valid_entry = valid_q;
  assign rd_entry    = head_q;
  assign rd_valid    = |(valid_q & head_q);
  assign count       = CntW'(popcount(MaxWidth'(valid_q), WIDTH));

endmodule
